iq_frame_packer: RTL and testbench

- Upstream producer for the A2F (FPGA-to-host) FIFO that the FT600 bus FSM drains.
- Takes 8-bit I/Q sample pairs from the SDR datapath and packs two pairs per 32-bit word.
- Wraps each group of FRAME_WORDS payload words in a header word that carries a sequence number and drop flag.
- Drops whole frames, never partial ones, when the FIFO lacks room, so the host stream stays frame-aligned.

---
 rtl/ft_pkg.sv | 36 +++
 rtl/iq_pair_packer.sv | 50 +++++
 rtl/iq_frame_packer.sv | 166 ++++++++++++++++
 tb/tb_iq_frame_packer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ft_pkg.sv
// ft_pkg: shared definitions for the FT600 A2F datapath.
//   - frame FSM state encoding (one-hot)
//   - header word field positions and a header builder
//   - default header sync marker and FT bus data width
package ft_pkg;

  localparam int unsigned FT_DATA_W         = 32;
  localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'hA5;

  // Header word layout: {sync[31:24], 7'b0, drop[16], seq[15:0]}
  localparam int unsigned HDR_SYNC_LSB = 24;
  localparam int unsigned HDR_DROP_BIT = 16;
  localparam int unsigned HDR_SEQ_LSB  = 0;
  localparam int unsigned HDR_SEQ_W    = 16;

  typedef enum logic [3:0] {
    ST_IDLE = 4'b0001,
    ST_SYNC = 4'b0010,
    ST_PACK = 4'b0100,
    ST_DROP = 4'b1000
  } state_e;

  function automatic logic [FT_DATA_W-1:0] make_header(
    input logic [7:0]           sync_byte,
    input logic                 drop_flag,
    input logic [HDR_SEQ_W-1:0] seq
  );
    logic [FT_DATA_W-1:0] hdr;
    hdr                              = '0;
    hdr[HDR_SYNC_LSB +: 8]           = sync_byte;
    hdr[HDR_DROP_BIT]                = drop_flag;
    hdr[HDR_SEQ_LSB +: HDR_SEQ_W]    = seq;
    return hdr;
  endfunction

endpackage

// File: rtl/iq_pair_packer.sv
// iq_pair_packer: packs two consecutive 8-bit I/Q sample pairs into one
// 32-bit word {q_odd, i_odd, q_even, i_even}.
// Ports:
//   clk, reset_n     clock / async active-low reset
//   clr_i            synchronous clear of the pairing phase (frame realign)
//   valid_i          sample pair presented this cycle
//   i_i, q_i         in-phase / quadrature sample
//   word_o           packed word (valid only with word_valid_o)
//   word_valid_o     combinational: high on the odd sample of a pair
module iq_pair_packer
  import ft_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clr_i,
  input  logic                 valid_i,
  input  logic [7:0]           i_i,
  input  logic [7:0]           q_i,
  output logic [FT_DATA_W-1:0] word_o,
  output logic                 word_valid_o
);

  logic        phase_q, phase_d;
  logic [15:0] low_q, low_d;

  always_comb begin
    phase_d = phase_q;
    low_d   = low_q;
    if (clr_i) begin
      phase_d = 1'b0;
    end else if (valid_i) begin
      phase_d = ~phase_q;
      if (!phase_q) low_d = {q_i, i_i};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_q <= 1'b0;
      low_q   <= 16'h0000;
    end else begin
      phase_q <= phase_d;
      low_q   <= low_d;
    end
  end

  assign word_o       = {q_i, i_i, low_q};
  assign word_valid_o = valid_i & phase_q & ~clr_i;

endmodule

// File: rtl/iq_frame_packer.sv
// iq_frame_packer: frames packed I/Q words for the FT600 A2F FIFO.
// Each frame is one header word followed by FRAME_WORDS payload words.
// A frame whose start finds the FIFO almost full is dropped whole; the
// next emitted header carries the drop flag.
// Ports:
//   clk, reset_n        clock / async active-low reset
//   enable              streaming enable, honoured at frame boundaries
//   iq_valid, i_data, q_data   incoming sample pair
//   fifo_afull, fifo_full      FIFO room status
//   fifo_wdata, fifo_wrreq     registered FIFO write port
//   drop_cnt            saturating dropped-frame counter
//   overflow_err        sticky: write issued while FIFO full
//   busy                high inside a frame (PACK or DROP)
//
// state | meaning
// IDLE  | streaming off, samples ignored
// SYNC  | frame boundary, waiting for sample 0
// PACK  | frame accepted, emitting payload words
// DROP  | frame rejected, discarding its samples
module iq_frame_packer
  import ft_pkg::*;
#(
  parameter int unsigned FRAME_WORDS = 1024,
  parameter logic [7:0]  SYNC_BYTE   = SYNC_BYTE_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic                 iq_valid,
  input  logic [7:0]           i_data,
  input  logic [7:0]           q_data,
  input  logic                 fifo_afull,
  input  logic                 fifo_full,
  output logic [FT_DATA_W-1:0] fifo_wdata,
  output logic                 fifo_wrreq,
  output logic [15:0]          drop_cnt,
  output logic                 overflow_err,
  output logic                 busy
);

  localparam int unsigned WCW = $clog2(FRAME_WORDS + 1);
  localparam int unsigned SCW = $clog2(2 * FRAME_WORDS + 1);
  localparam logic [WCW-1:0] WC_LAST = WCW'(FRAME_WORDS - 1);
  localparam logic [SCW-1:0] SC_LAST = SCW'(2 * FRAME_WORDS - 1);

  state_e               state_q, state_d;
  logic [15:0]          seq_q, seq_d;
  logic [WCW-1:0]       word_cnt_q, word_cnt_d;
  logic [SCW-1:0]       smp_cnt_q, smp_cnt_d;
  logic                 drop_pending_q, drop_pending_d;
  logic [15:0]          drop_cnt_q, drop_cnt_d;
  logic                 overflow_q, overflow_d;
  logic                 wrreq_q, wrreq_d;
  logic [FT_DATA_W-1:0] wdata_q, wdata_d;
  logic                 busy_o;

  logic                 pk_feed, pk_clr, pair_valid;
  logic [FT_DATA_W-1:0] pair_word;
  logic                 sof;

  // sample 0 of a frame is accepted in SYNC (enabled), paired samples in PACK
  assign sof     = (state_q == ST_SYNC) & enable & iq_valid;
  assign pk_feed = sof | ((state_q == ST_PACK) & iq_valid);
  // DROP must leave the pairing phase realigned for the next frame
  assign pk_clr  = (state_q == ST_IDLE) | (state_q == ST_DROP);

  iq_pair_packer u_pair (
    .clk          (clk),
    .reset_n      (reset_n),
    .clr_i        (pk_clr),
    .valid_i      (pk_feed),
    .i_i          (i_data),
    .q_i          (q_data),
    .word_o       (pair_word),
    .word_valid_o (pair_valid)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (enable) state_d = ST_SYNC;
      ST_SYNC: begin
        if (!enable)        state_d = ST_IDLE;
        else if (iq_valid)  state_d = fifo_afull ? ST_DROP : ST_PACK;
      end
      ST_PACK: if (pair_valid && word_cnt_q == WC_LAST) state_d = ST_SYNC;
      ST_DROP: if (iq_valid && smp_cnt_q == SC_LAST)    state_d = ST_SYNC;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    seq_d          = seq_q;
    word_cnt_d     = word_cnt_q;
    smp_cnt_d      = smp_cnt_q;
    drop_pending_d = drop_pending_q;
    drop_cnt_d     = drop_cnt_q;
    wrreq_d        = 1'b0;
    wdata_d        = wdata_q;
    // the FIFO sees the write in the cycle wrreq_q is high
    overflow_d     = overflow_q | (wrreq_q & fifo_full);
    busy_o         = (state_q == ST_PACK) || (state_q == ST_DROP);
    case (state_q)
      ST_SYNC: begin
        if (sof) begin
          seq_d = seq_q + 16'd1;
          if (!fifo_afull) begin
            wrreq_d        = 1'b1;
            wdata_d        = make_header(SYNC_BYTE, drop_pending_q, seq_q);
            drop_pending_d = 1'b0;
            word_cnt_d     = '0;
          end else begin
            smp_cnt_d      = SCW'(1);
            drop_pending_d = 1'b1;
            if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
          end
        end
      end
      ST_PACK: begin
        if (pair_valid) begin
          wrreq_d    = 1'b1;
          wdata_d    = pair_word;
          word_cnt_d = word_cnt_q + WCW'(1);
        end
      end
      ST_DROP: begin
        if (iq_valid) smp_cnt_d = smp_cnt_q + SCW'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seq_q          <= 16'h0000;
      word_cnt_q     <= '0;
      smp_cnt_q      <= '0;
      drop_pending_q <= 1'b0;
      drop_cnt_q     <= 16'h0000;
      overflow_q     <= 1'b0;
      wrreq_q        <= 1'b0;
      wdata_q        <= '0;
    end else begin
      seq_q          <= seq_d;
      word_cnt_q     <= word_cnt_d;
      smp_cnt_q      <= smp_cnt_d;
      drop_pending_q <= drop_pending_d;
      drop_cnt_q     <= drop_cnt_d;
      overflow_q     <= overflow_d;
      wrreq_q        <= wrreq_d;
      wdata_q        <= wdata_d;
    end
  end

  assign fifo_wrreq   = wrreq_q;
  assign fifo_wdata   = wdata_q;
  assign drop_cnt     = drop_cnt_q;
  assign overflow_err = overflow_q;
  assign busy         = busy_o;

endmodule

// File: tb/tb_iq_frame_packer.sv
module tb_iq_frame_packer;

  logic        clk;
  logic        reset_n;
  logic        enable;
  logic        iq_valid;
  logic [7:0]  i_data;
  logic [7:0]  q_data;
  logic        fifo_afull;
  logic        fifo_full;
  logic [31:0] fifo_wdata;
  logic        fifo_wrreq;
  logic [15:0] drop_cnt;
  logic        overflow_err;
  logic        busy;

  iq_frame_packer #(.FRAME_WORDS(4), .SYNC_BYTE(8'hA5)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .iq_valid     (iq_valid),
    .i_data       (i_data),
    .q_data       (q_data),
    .fifo_afull   (fifo_afull),
    .fifo_full    (fifo_full),
    .fifo_wdata   (fifo_wdata),
    .fifo_wrreq   (fifo_wrreq),
    .drop_cnt     (drop_cnt),
    .overflow_err (overflow_err),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] word;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] wr_log[$];
  int          cyc_m = 0;
  int          n_vec = 0;
  int          n_err = 0;

  // reference model state
  logic [15:0] mdl_seq  = 16'h0000;
  logic        mdl_pend = 1'b0;
  logic [15:0] mdl_drop = 16'h0000;
  logic        mdl_dropping = 1'b0;
  logic [15:0] mdl_lo = 16'h0000;

  // scoreboard: every observed write pops one expected word + cycle
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc_m++;
      if (fifo_wrreq === 1'b1) begin
        wr_log.push_back(fifo_wdata);
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_write: got %h at cycle %0d, required no write", fifo_wdata, cyc_m);
        end else begin
          e = exp_q.pop_front();
          if (fifo_wdata !== e.word) begin
            n_err++;
            $display("FAIL write_data: got %h, required %h", fifo_wdata, e.word);
          end
          n_vec++;
          if (cyc_m !== e.cyc) begin
            n_err++;
            $display("FAIL write_latency: got cycle %0d, required cycle %0d", cyc_m, e.cyc);
          end
        end
      end
    end
  end

  task automatic push_exp(input logic [31:0] w);
    exp_t e;
    e.word = w;
    e.cyc  = cyc_m + 1;
    exp_q.push_back(e);
  endtask

  // drive samples first..last of a frame (i=base+n, q=base+n+0x80)
  task automatic drive_samples(input int first, input int last, input logic [7:0] base,
                               input int gap, input bit afull0, input int full_at,
                               input int en_off_after);
    for (int n = first; n <= last; n++) begin
      @(negedge clk);
      if (en_off_after >= 0 && n > en_off_after) enable = 1'b0;
      iq_valid   = 1'b1;
      i_data     = base + 8'(n);
      q_data     = base + 8'(n) + 8'h80;
      fifo_afull = (n == 0) ? afull0 : (n == 3);
      fifo_full  = (full_at >= 0) && ((n == full_at) || (n == full_at + 1));
      if (n == 0) begin
        mdl_dropping = afull0;
        if (!afull0) begin
          push_exp({8'hA5, 7'b0, mdl_pend, mdl_seq});
          mdl_pend = 1'b0;
        end else begin
          mdl_pend = 1'b1;
          if (mdl_drop != 16'hFFFF) mdl_drop = mdl_drop + 16'd1;
        end
        mdl_seq = mdl_seq + 16'd1;
      end
      if (!mdl_dropping) begin
        if (n % 2 == 0) mdl_lo = {q_data, i_data};
        else            push_exp({q_data, i_data, mdl_lo});
      end
      repeat (gap) begin
        @(negedge clk);
        iq_valid = 1'b0;
      end
    end
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      @(negedge clk);
      iq_valid   = 1'b0;
      fifo_full  = 1'b0;
      fifo_afull = 1'b0;
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b1; enable = 1'b0; iq_valid = 1'b0; i_data = 8'h00; q_data = 8'h00;
    fifo_afull = 1'b0; fifo_full = 1'b0;
    #2 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++; if (fifo_wrreq !== 1'b0)     begin n_err++; $display("FAIL rst_wrreq: got %b, required 0", fifo_wrreq); end
    n_vec++; if (fifo_wdata !== 32'h0)    begin n_err++; $display("FAIL rst_wdata: got %h, required 00000000", fifo_wdata); end
    n_vec++; if (drop_cnt !== 16'h0)      begin n_err++; $display("FAIL rst_drop_cnt: got %h, required 0000", drop_cnt); end
    n_vec++; if (overflow_err !== 1'b0)   begin n_err++; $display("FAIL rst_overflow: got %b, required 0", overflow_err); end
    n_vec++; if (busy !== 1'b0)           begin n_err++; $display("FAIL rst_busy: got %b, required 0", busy); end
    reset_n = 1'b1;
    // samples while IDLE must be ignored
    @(negedge clk); iq_valid = 1'b1;
    @(negedge clk); iq_valid = 1'b1;
    idle(2);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_busy: got %b, required 0", busy); end
  endtask

  task automatic test_basic_frame;
    logic [31:0] lit[5];
    lit[0] = 32'hA5000000; lit[1] = 32'h81018000; lit[2] = 32'h83038202;
    lit[3] = 32'h85058404; lit[4] = 32'h87078606;
    wr_log.delete();
    @(negedge clk); enable = 1'b1;
    drive_samples(0, 3, 8'h00, 0, 1'b0, -1, -1);
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL pack_busy: got %b, required 1", busy); end
    drive_samples(4, 7, 8'h00, 0, 1'b0, -1, -1);
    idle(3);
    n_vec++;
    if (wr_log.size() != 5) begin
      n_err++; $display("FAIL basic_count: got %0d writes, required 5", wr_log.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        n_vec++;
        if (wr_log[k] !== lit[k]) begin n_err++; $display("FAIL basic_word%0d: got %h, required %h", k, wr_log[k], lit[k]); end
      end
    end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL basic_end_busy: got %b, required 0", busy); end
  endtask

  task automatic test_drop;
    wr_log.delete();
    drive_samples(0, 3, 8'h10, 0, 1'b1, -1, -1);
    n_vec++; if (busy !== 1'b1)       begin n_err++; $display("FAIL drop_busy: got %b, required 1", busy); end
    n_vec++; if (drop_cnt !== mdl_drop) begin n_err++; $display("FAIL drop_cnt_mid: got %h, required %h", drop_cnt, mdl_drop); end
    drive_samples(4, 7, 8'h10, 0, 1'b1, -1, -1);
    idle(2);
    n_vec++; if (wr_log.size() != 0)  begin n_err++; $display("FAIL drop_no_write: got %0d writes, required 0", wr_log.size()); end
    n_vec++; if (drop_cnt !== 16'h0001) begin n_err++; $display("FAIL drop_cnt: got %h, required 0001", drop_cnt); end
    drive_samples(0, 7, 8'h20, 0, 1'b0, -1, -1);
    drive_samples(0, 7, 8'h30, 0, 1'b0, -1, -1);
    idle(3);
    n_vec++;
    if (wr_log.size() != 10) begin
      n_err++; $display("FAIL drop_after_count: got %0d writes, required 10", wr_log.size());
    end else begin
      n_vec++; if (wr_log[0] !== 32'hA5010002) begin n_err++; $display("FAIL drop_flag_hdr: got %h, required A5010002", wr_log[0]); end
      n_vec++; if (wr_log[5] !== 32'hA5000003) begin n_err++; $display("FAIL drop_flag_clear: got %h, required A5000003", wr_log[5]); end
    end
  endtask

  task automatic test_gapped;
    wr_log.delete();
    drive_samples(0, 7, 8'h40, 2, 1'b0, -1, -1);
    drive_samples(0, 7, 8'h50, 2, 1'b0, -1, -1);
    idle(3);
    n_vec++; if (wr_log.size() != 10) begin n_err++; $display("FAIL gap_count: got %0d writes, required 10", wr_log.size()); end
    n_vec++; if (exp_q.size() != 0)   begin n_err++; $display("FAIL gap_missing: got %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_enable_off;
    wr_log.delete();
    drive_samples(0, 7, 8'h60, 0, 1'b0, -1, 3);
    idle(3);
    n_vec++; if (wr_log.size() != 5) begin n_err++; $display("FAIL en_off_count: got %0d writes, required 5", wr_log.size()); end
    n_vec++; if (busy !== 1'b0)      begin n_err++; $display("FAIL en_off_busy: got %b, required 0", busy); end
    repeat (4) begin @(negedge clk); iq_valid = 1'b1; end
    idle(2);
    wr_log.delete();
    @(negedge clk); enable = 1'b1;
    drive_samples(0, 7, 8'h70, 0, 1'b0, -1, -1);
    idle(3);
    n_vec++;
    if (wr_log.size() == 0) begin
      n_err++; $display("FAIL en_resume_count: got 0 writes, required 5");
    end else if (wr_log[0] !== 32'hA5000007) begin
      n_err++; $display("FAIL en_resume_hdr: got %h, required A5000007", wr_log[0]);
    end
  endtask

  task automatic test_fifo_full;
    wr_log.delete();
    n_vec++; if (overflow_err !== 1'b0) begin n_err++; $display("FAIL ovf_pre: got %b, required 0", overflow_err); end
    drive_samples(0, 7, 8'h80, 0, 1'b0, 3, -1);
    idle(3);
    n_vec++; if (wr_log.size() != 5)    begin n_err++; $display("FAIL ovf_count: got %0d writes, required 5", wr_log.size()); end
    n_vec++; if (overflow_err !== 1'b1) begin n_err++; $display("FAIL ovf_set: got %b, required 1", overflow_err); end
    drive_samples(0, 7, 8'h90, 0, 1'b0, -1, -1);
    idle(3);
    n_vec++; if (overflow_err !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b, required 1", overflow_err); end
  endtask

  task automatic test_async_reset;
    wr_log.delete();
    drive_samples(0, 5, 8'hA0, 0, 1'b0, -1, -1);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    n_vec++; if (fifo_wrreq !== 1'b0)   begin n_err++; $display("FAIL arst_wrreq: got %b, required 0", fifo_wrreq); end
    n_vec++; if (fifo_wdata !== 32'h0)  begin n_err++; $display("FAIL arst_wdata: got %h, required 00000000", fifo_wdata); end
    n_vec++; if (drop_cnt !== 16'h0)    begin n_err++; $display("FAIL arst_drop_cnt: got %h, required 0000", drop_cnt); end
    n_vec++; if (overflow_err !== 1'b0) begin n_err++; $display("FAIL arst_overflow: got %b, required 0", overflow_err); end
    n_vec++; if (busy !== 1'b0)         begin n_err++; $display("FAIL arst_busy: got %b, required 0", busy); end
    iq_valid = 1'b0; enable = 1'b0;
    mdl_seq = 16'h0000; mdl_pend = 1'b0; mdl_drop = 16'h0000;
    @(negedge clk); reset_n = 1'b1;
    idle(3);
    n_vec++; if (wr_log.size() != 4) begin n_err++; $display("FAIL arst_trailing: got %0d writes, required 4", wr_log.size()); end
    wr_log.delete();
    @(negedge clk); enable = 1'b1;
    drive_samples(0, 7, 8'hB0, 0, 1'b0, -1, -1);
    idle(3);
    n_vec++;
    if (wr_log.size() == 0) begin
      n_err++; $display("FAIL arst_resume_count: got 0 writes, required 5");
    end else if (wr_log[0] !== 32'hA5000000) begin
      n_err++; $display("FAIL arst_resume_hdr: got %h, required A5000000", wr_log[0]);
    end
    n_vec++; if (drop_cnt !== 16'h0) begin n_err++; $display("FAIL arst_resume_drop: got %h, required 0000", drop_cnt); end
    n_vec++; if (exp_q.size() != 0)  begin n_err++; $display("FAIL final_missing: got %0d pending, required 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_drop();
    test_gapped();
    test_enable_off();
    test_fifo_full();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
